// File: rtl/bus_pkg.sv
// Shared definitions for the serial shared bus: arbiter FSM states,
// line polarities used by arbiter, masters and slaves, and a width helper.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_TURN  = 2'd3
    } arb_state_t;

    // b_bus_utilizing is wired-OR with a weak pulldown: high means a frame is on the bus.
    localparam logic BUS_UTIL_ACTIVE   = 1'b1;
    localparam logic SLV_BUSY_DRIVE_ON = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((32'd1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner selection: round-robin search from a pointer with wrap,
// or fixed priority (lowest index) when i_fixed is set.
module rr_priority_picker
    import bus_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    input  logic            i_fixed,
    output logic [N-1:0]    o_onehot,
    output logic [ID_W-1:0] o_id,
    output logic            o_any
);

    logic [ID_W-1:0]  w_base;
    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [ID_W-1:0]  w_off;
    logic             w_found;
    logic [ID_W:0]    w_sum;

    // Rotate the request vector so the search start sits at bit 0, find the
    // first set bit, then map the offset back to an absolute index.
    always_comb begin
        w_base  = i_fixed ? '0 : i_ptr;
        w_dbl   = {i_req, i_req} >> w_base;
        w_rot   = w_dbl[N-1:0];
        w_off   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = ID_W'(k);
            end
        end
        w_sum = {1'b0, w_base} + {1'b0, w_off};
        if (w_sum >= (ID_W+1)'(N)) begin
            w_sum = w_sum - (ID_W+1)'(N);
        end
        o_id     = w_sum[ID_W-1:0];
        o_any    = |i_req;
        o_onehot = o_any ? ({{(N-1){1'b0}}, 1'b1} << o_id) : '0;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master arbiter for the shared serial bus: registered one-hot grants,
// round-robin or fixed priority, idle timeout, tenure pre-emption, turnaround.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_LEN = 6,
    parameter int HOLD_LEN    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 prio_mode,
    input  logic                 bus_util,
    output logic [N_MASTERS-1:0] grant,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 slv_bsy_drive,
    output logic                 timeout_pulse,
    output logic                 preempt_pulse
);

    localparam logic [TIMEOUT_LEN-1:0] IDLE_MAX   = '1;
    localparam logic [HOLD_LEN-1:0]    TENURE_MAX = '1;

    arb_state_t                 r_state, w_state_nxt;
    logic [N_MASTERS-1:0]       r_grant, w_grant_nxt;
    logic [ID_W-1:0]            r_id, w_id_nxt;
    logic [ID_W-1:0]            r_ptr, w_ptr_nxt;
    logic [TIMEOUT_LEN-1:0]     r_idle, w_idle_nxt;
    logic [HOLD_LEN-1:0]        r_tenure, w_tenure_nxt;
    logic                       r_tp, w_tp_nxt;
    logic                       r_pp, w_pp_nxt;

    logic [N_MASTERS-1:0]       w_pick;
    logic [ID_W-1:0]            w_pick_id;
    logic                       w_pick_any;
    logic                       w_busy;
    logic                       w_own_req;
    logic                       w_others;

    rr_priority_picker #(
        .N    (N_MASTERS),
        .ID_W (ID_W)
    ) u_picker (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .i_fixed  (prio_mode),
        .o_onehot (w_pick),
        .o_id     (w_pick_id),
        .o_any    (w_pick_any)
    );

    assign w_busy    = (bus_util == BUS_UTIL_ACTIVE);
    assign w_own_req = |(req & r_grant);
    assign w_others  = |(req & ~r_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_id     <= '0;
            r_ptr    <= '0;
            r_idle   <= '0;
            r_tenure <= '0;
            r_tp     <= 1'b0;
            r_pp     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_id     <= w_id_nxt;
            r_ptr    <= w_ptr_nxt;
            r_idle   <= w_idle_nxt;
            r_tenure <= w_tenure_nxt;
            r_tp     <= w_tp_nxt;
            r_pp     <= w_pp_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_id_nxt     = r_id;
        w_ptr_nxt    = r_ptr;
        w_idle_nxt   = r_idle;
        w_tenure_nxt = r_tenure;
        w_tp_nxt     = 1'b0;
        w_pp_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Counters start at 1 so they count granted cycles including the first.
                if (w_pick_any) begin
                    w_state_nxt  = ST_GRANT;
                    w_grant_nxt  = w_pick;
                    w_id_nxt     = w_pick_id;
                    w_idle_nxt   = TIMEOUT_LEN'(1);
                    w_tenure_nxt = HOLD_LEN'(1);
                end
            end
            ST_GRANT: begin
                if (!w_own_req) begin
                    if (w_busy) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_TURN;
                        w_grant_nxt = '0;
                    end
                end else if (!w_busy && r_idle == IDLE_MAX) begin
                    w_state_nxt = ST_TURN;
                    w_grant_nxt = '0;
                    w_tp_nxt    = 1'b1;
                end else if (!w_busy && r_tenure == TENURE_MAX && w_others) begin
                    w_state_nxt = ST_TURN;
                    w_grant_nxt = '0;
                    w_pp_nxt    = 1'b1;
                end else begin
                    w_idle_nxt   = w_busy ? '0 : ((r_idle == IDLE_MAX) ? r_idle : r_idle + 1'b1);
                    w_tenure_nxt = (r_tenure == TENURE_MAX) ? r_tenure : r_tenure + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!w_busy) begin
                    w_state_nxt = ST_TURN;
                    w_grant_nxt = '0;
                end
            end
            ST_TURN: begin
                w_state_nxt  = ST_IDLE;
                w_ptr_nxt    = (r_id == ID_W'(N_MASTERS - 1)) ? '0 : r_id + 1'b1;
                w_idle_nxt   = '0;
                w_tenure_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign grant         = r_grant;
    assign grant_valid   = |r_grant;
    assign grant_id      = r_id;
    assign slv_bsy_drive = (r_state == ST_TURN) ? SLV_BUSY_DRIVE_ON : ~SLV_BUSY_DRIVE_ON;
    assign timeout_pulse = r_tp;
    assign preempt_pulse = r_pp;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomized scoreboard bench for bus_arbiter_rr (4 masters, 4-bit counters).
module tb_bus_arbiter_rr;

    localparam int N     = 4;
    localparam int LIMIT = 15;

    typedef struct packed {
        logic [3:0] g;
        logic       gv;
        logic [1:0] id;
        logic       slv;
        logic       tp;
        logic       pp;
    } exp_t;

    typedef struct {
        int cycles;
        bit fixed;
        int bu_pct;
        int long_pct;
        int raise_pct;
    } phase_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       prio_mode;
    logic       bus_util;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       slv_bsy_drive;
    logic       timeout_pulse;
    logic       preempt_pulse;

    bus_arbiter_rr #(
        .N_MASTERS   (4),
        .ID_W        (2),
        .TIMEOUT_LEN (4),
        .HOLD_LEN    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .prio_mode     (prio_mode),
        .bus_util      (bus_util),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .slv_bsy_drive (slv_bsy_drive),
        .timeout_pulse (timeout_pulse),
        .preempt_pulse (preempt_pulse)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   failures  = 0;
    bit   stim_done = 1'b0;
    exp_t sb[$];

    // Reference model: who owns the bus, whether it is draining or in the
    // turnaround cycle, how long it has held the bus and where RR resumes.
    int m_owner, m_last, m_next, m_idle, m_tenure;
    bit m_drain, m_turn, m_tp, m_pp;
    int hold_left[N];
    bit was_granted[N];

    function automatic int pick(input logic [3:0] r, input bit fixed, input int start);
        int s = fixed ? 0 : start;
        for (int k = 0; k < N; k++) begin
            if (r[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        m_tp = 1'b0;
        m_pp = 1'b0;
        if (rst) begin
            m_owner = -1; m_last = 0; m_next = 0; m_idle = 0; m_tenure = 0;
            m_drain = 1'b0; m_turn = 1'b0;
        end else if (m_turn) begin
            m_turn   = 1'b0;
            m_next   = (m_last + 1) % N;
            m_idle   = 0;
            m_tenure = 0;
        end else if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner  = pick(req, prio_mode, m_next);
                m_last   = m_owner;
                m_idle   = 1;
                m_tenure = 1;
            end
        end else if (m_drain) begin
            if (!bus_util) begin
                m_owner = -1; m_drain = 1'b0; m_turn = 1'b1;
            end
        end else if (!req[m_owner]) begin
            if (bus_util) m_drain = 1'b1;
            else begin m_owner = -1; m_turn = 1'b1; end
        end else if (!bus_util && m_idle == LIMIT) begin
            m_owner = -1; m_turn = 1'b1; m_tp = 1'b1;
        end else if (!bus_util && m_tenure == LIMIT && (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
            m_owner = -1; m_turn = 1'b1; m_pp = 1'b1;
        end else begin
            m_idle   = bus_util ? 0 : ((m_idle < LIMIT) ? m_idle + 1 : LIMIT);
            m_tenure = (m_tenure < LIMIT) ? m_tenure + 1 : LIMIT;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.g   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.gv  = (m_owner >= 0);
        e.id  = 2'(m_last);
        e.slv = m_turn;
        e.tp  = m_tp;
        e.pp  = m_pp;
        return e;
    endfunction

    task automatic drive_masters(input phase_t ph);
        for (int i = 0; i < N; i++) begin
            bit g = (m_owner == i);
            if (g && !was_granted[i]) begin
                hold_left[i] = ($urandom_range(0, 99) < ph.long_pct) ? $urandom_range(10, 24)
                                                                      : $urandom_range(1, 4);
            end
            was_granted[i] = g;
            if (req[i]) begin
                if (g) begin
                    if (hold_left[i] > 0) hold_left[i]--;
                    if (hold_left[i] == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end else if ($urandom_range(0, 99) < ph.raise_pct) begin
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic stimulus();
        phase_t phases[6];
        phases[0] = '{300, 1'b0, 0,  20, 50};
        phases[1] = '{300, 1'b0, 10, 60, 40};
        phases[2] = '{300, 1'b0, 50, 30, 40};
        phases[3] = '{300, 1'b1, 0,  20, 50};
        phases[4] = '{300, 1'b1, 30, 40, 40};
        phases[5] = '{300, 1'b0, 10, 80, 20};
        for (int i = 0; i < N; i++) begin
            hold_left[i] = 0;
            was_granted[i] = 1'b0;
        end
        // All masters requesting while reset is held for two cycles.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b1; req = 4'b1111; prio_mode = 1'b0; bus_util = 1'b0;
            model_step();
            sb.push_back(model_out());
        end
        foreach (phases[p]) begin
            for (int c = 0; c < phases[p].cycles; c++) begin
                @(negedge clk);
                rst       = ($urandom_range(0, 249) == 0);
                prio_mode = phases[p].fixed;
                bus_util  = ($urandom_range(0, 99) < phases[p].bu_pct);
                drive_masters(phases[p]);
                model_step();
                sb.push_back(model_out());
            end
        end
        @(negedge clk);
        stim_done = 1'b1;
    endtask

    task automatic monitor();
        int budget = 5000;
        while (!(stim_done && sb.size() == 0)) begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e   = sb.pop_front();
                exp_t got = {grant, grant_valid, grant_id, slv_bsy_drive, timeout_pulse, preempt_pulse};
                checks++;
                if (got !== e) begin
                    failures++;
                    if (failures <= 20) begin
                        $display("FAIL outputs t=%0t: grant/gv/id/slv/tp/pp got %b/%b/%0d/%b/%b/%b required %b/%b/%0d/%b/%b/%b",
                                 $time, got.g, got.gv, got.id, got.slv, got.tp, got.pp,
                                 e.g, e.gv, e.id, e.slv, e.tp, e.pp);
                    end
                end
            end
            budget--;
            if (budget == 0) begin
                failures++;
                $display("FAIL monitor_budget: got %0d pending entries, required 0", sb.size());
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; prio_mode = 1'b0; bus_util = 1'b0;
        fork
            stimulus();
            monitor();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
